// File: rtl/lifo_stack_pkg.sv
// lifo_stack_pkg: operation encoding and decode for the LIFO stack
package lifo_stack_pkg;
  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } op_t;
  function automatic op_t decode_op(input logic push, input logic pop);
    return op_t'({push, pop});
  endfunction
endpackage

// File: rtl/lifo_stack_mem.sv
// lifo_stack_mem: DEPTH x WIDTH register array, sync write, comb read
module lifo_stack_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  // non-power-of-two depths leave unused addresses; read them as zero
  assign rdata = (int'(raddr) < DEPTH) ? mem[raddr] : '0;
endmodule

// File: rtl/lifo_stack_p.sv
// lifo_stack_p: parametrised LIFO with count, flags, sticky errors and registered top
module lifo_stack_p
  import lifo_stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] value_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] value_out,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW = $clog2(DEPTH);
  op_t op;
  logic do_push, do_repl, do_pop, we;
  logic [AW-1:0] waddr, raddr;
  logic [WIDTH-1:0] rdata, value_n;
  logic [CW-1:0] count_n;
  logic overflow_n, underflow_n;
  lifo_stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk), .we(we), .waddr(waddr), .wdata(value_in), .raddr(raddr), .rdata(rdata)
  );
  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
  assign op    = decode_op(push, pop);
  // replace on an empty stack degenerates into a push
  always_comb begin
    do_push     = (op == OP_PUSH && !full) || (op == OP_REPLACE && empty);
    do_repl     = op == OP_REPLACE && !empty;
    do_pop      = op == OP_POP && !empty;
    we          = do_push || do_repl;
    waddr       = do_push ? AW'(count) : AW'(count - 1'b1);
    raddr       = AW'(count - CW'(2));
    count_n     = do_push ? count + 1'b1 : do_pop ? count - 1'b1 : count;
    value_n     = we ? value_in : do_pop ? (count == CW'(1) ? '0 : rdata) : value_out;
    overflow_n  = (op == OP_PUSH && full) || (overflow && !err_clr);
    underflow_n = ((op == OP_POP || op == OP_REPLACE) && empty) || (underflow && !err_clr);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count     <= '0;
      value_out <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_n;
      value_out <= value_n;
      overflow  <= overflow_n;
      underflow <= underflow_n;
    end
endmodule

// File: tb/tb_lifo_stack_p.sv
// tb_lifo_stack_p: directed self-checking bench for lifo_stack_p (16x8 and 32x5)
module tb_lifo_stack_p;
  logic clk = 0, reset = 0;
  logic push = 0, pop = 0, err_clr = 0;
  logic [15:0] value_in = '0;
  logic [15:0] value_out;
  logic [3:0] count;
  logic empty, full, overflow, underflow;
  logic push1 = 0, pop1 = 0;
  logic [31:0] value_in1 = '0;
  logic [31:0] value_out1;
  logic [2:0] count1;
  logic empty1, full1, overflow1, underflow1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  lifo_stack_p #(.WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .value_in(value_in), .err_clr(err_clr),
    .value_out(value_out), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );
  lifo_stack_p #(.WIDTH(32), .DEPTH(5)) dut1 (
    .clk(clk), .reset(reset), .push(push1), .pop(pop1), .value_in(value_in1), .err_clr(1'b0),
    .value_out(value_out1), .count(count1), .empty(empty1), .full(full1),
    .overflow(overflow1), .underflow(underflow1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic p, input logic q, input logic [15:0] v, input logic e);
    @(negedge clk);
    push = p; pop = q; value_in = v; err_clr = e;
    @(posedge clk); #1;
    push = 0; pop = 0; err_clr = 0;
  endtask

  task automatic op1(input logic p, input logic q, input logic [31:0] v);
    @(negedge clk);
    push1 = p; pop1 = q; value_in1 = v;
    @(posedge clk); #1;
    push1 = 0; pop1 = 0;
  endtask

  initial begin
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_udf", 32'(underflow), 0);
    chk("rst_vout", 32'(value_out), 0);
    @(negedge clk); reset = 1;
    for (int i = 1; i <= 8; i++) begin
      op(1, 0, 16'(16'h11 * i), 0);
      chk("push_count", 32'(count), 32'(i));
      chk("push_vout", 32'(value_out), 32'(16'h11 * i));
      chk("push_full", 32'(full), 32'(i == 8));
    end
    chk("push_ovf", 32'(overflow), 0);
    op(1, 0, 16'h00FF, 0);
    chk("ovf_count", 32'(count), 8);
    chk("ovf_vout", 32'(value_out), 32'h88);
    chk("ovf_set", 32'(overflow), 1);
    op(0, 0, 16'h0, 1);
    chk("ovf_clr", 32'(overflow), 0);
    for (int i = 7; i >= 0; i--) begin
      op(0, 1, 16'h0, 0);
      chk("pop_count", 32'(count), 32'(i));
      chk("pop_vout", 32'(value_out), 32'(16'h11 * i));
    end
    chk("pop_empty", 32'(empty), 1);
    op(0, 1, 16'h0, 0);
    chk("udf_set", 32'(underflow), 1);
    chk("udf_count", 32'(count), 0);
    op(0, 1, 16'h0, 1);
    chk("udf_set_wins", 32'(underflow), 1);
    op(0, 0, 16'h0, 1);
    chk("udf_clr", 32'(underflow), 0);
    op(1, 0, 16'h1234, 0);
    op(1, 0, 16'h5678, 0);
    op(1, 1, 16'hABCD, 0);
    chk("repl_count", 32'(count), 2);
    chk("repl_vout", 32'(value_out), 32'hABCD);
    chk("repl_flags", 32'({overflow, underflow}), 0);
    op(0, 1, 16'h0, 0);
    chk("repl_pop_vout", 32'(value_out), 32'h1234);
    op(0, 1, 16'h0, 0);
    chk("repl_pop_empty", 32'(empty), 1);
    op(1, 1, 16'h0042, 0);
    chk("repl_e_count", 32'(count), 1);
    chk("repl_e_vout", 32'(value_out), 32'h42);
    chk("repl_e_udf", 32'(underflow), 1);
    for (int i = 0; i < 4; i++) op(1, 0, 16'(i + 1), 0);
    chk("mid_count", 32'(count), 5);
    op(1, 1, 16'h0099, 0);
    chk("full_repl_count", 32'(count), 5);
    #2 reset = 0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_vout", 32'(value_out), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_flags", 32'({overflow, underflow}), 0);
    @(negedge clk); push = 1; value_in = 16'h7777;
    @(posedge clk); #1; push = 0;
    chk("arst_hold", 32'(count), 0);
    @(negedge clk); reset = 1;
    op(1, 0, 16'h0101, 0);
    chk("post_rst_count", 32'(count), 1);
    chk("post_rst_vout", 32'(value_out), 32'h0101);
    for (int i = 1; i <= 5; i++) begin
      op1(1, 0, 32'h11 * i);
      chk("w32_count", 32'(count1), 32'(i));
      chk("w32_vout", value_out1, 32'h11 * i);
    end
    chk("w32_full", 32'(full1), 1);
    op1(1, 0, 32'hDEAD_BEEF);
    chk("w32_ovf", 32'(overflow1), 1);
    chk("w32_ovf_vout", value_out1, 32'h55);
    for (int i = 4; i >= 0; i--) begin
      op1(0, 1, 32'h0);
      chk("w32_pop_vout", value_out1, 32'h11 * i);
    end
    chk("w32_empty", 32'(empty1), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
